console_txfifo: RTL and testbench

- Byte-wide transmit FIFO between the CPU's console-write instruction and the simpleuart data port.
- The CPU pushes a byte in one cycle instead of stalling for the whole UART frame time.
- A drain state machine pops bytes and performs the simpleuart write handshake (reg_dat_we held until reg_dat_wait drops).
- Status outputs (full, empty, level, sticky overflow) let the CPU poll before pushing.

---
 rtl/console_txfifo.sv | 117 +++++++++++
 tb/tb_console_txfifo.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/console_txfifo.sv
// Byte-wide transmit FIFO feeding the simpleuart data port.
// The CPU pushes one byte per cycle; a three-state drain machine pops bytes
// and holds uart_dat_we until the UART drops uart_dat_wait.
module console_txfifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr_overflow,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          uart_dat_we,
  output logic [31:0]   uart_dat_di,
  input  logic          uart_dat_wait
);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  localparam logic [AW:0] PtrOne   = (AW+1)'(1);
  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [7:0]  dat_q, dat_d;
  logic        overflow_q;
  logic        push;
  logic        drop;

  // Status comes only from registered pointers; no path from wr_en.
  assign level       = wr_ptr_q - rd_ptr_q;
  assign empty       = (level == '0);
  assign full        = (level == DepthCnt);
  assign push        = wr_en && !full;
  assign drop        = wr_en && full;
  assign overflow    = overflow_q;
  assign uart_dat_we = we_q;
  assign uart_dat_di = {24'b0, dat_q};

  // Storage write; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  // Write pointer and sticky overflow; a drop in the same cycle beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clr_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Drain machine state, read pointer and UART-side output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      we_q     <= 1'b0;
      dat_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      we_q     <= we_d;
      dat_q    <= dat_d;
    end
  end

  // Next-state: load a byte, hold it until the UART accepts, then force a low cycle.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    we_d     = we_q;
    dat_d    = dat_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          dat_d   = mem[rd_ptr_q[AW-1:0]];
          we_d    = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (!uart_dat_wait) begin
          rd_ptr_d = rd_ptr_q + PtrOne;
          we_d     = 1'b0;
          state_d  = StGap;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        we_d    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_console_txfifo.sv
// Self-checking bench for console_txfifo: queue-based reference model,
// simpleuart-like wait generator and a decoupled output monitor.
module tb_console_txfifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        clr_overflow;
  logic        full;
  logic        empty;
  logic [AW:0] level;
  logic        overflow;
  logic        uart_dat_we;
  logic [31:0] uart_dat_di;
  logic        uart_dat_wait;

  logic        hold_wait = 1'b0;
  logic        busy      = 1'b0;
  int          remaining = 0;
  int          wmin      = 0;
  int          wmax      = 0;

  // Reference model: FIFO contents as a queue, entry count, sticky flag.
  logic [7:0]  exp_q[$];
  int          cnt    = 0;
  logic        ovf    = 1'b0;
  int          pushed = 0;
  int          sent   = 0;

  int          checks = 0;
  int          errors = 0;

  assign uart_dat_wait = hold_wait | busy;

  console_txfifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .clr_overflow  (clr_overflow),
    .full          (full),
    .empty         (empty),
    .level         (level),
    .overflow      (overflow),
    .uart_dat_we   (uart_dat_we),
    .uart_dat_di   (uart_dat_di),
    .uart_dat_wait (uart_dat_wait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: compare status against the model, then drive inputs.
  task automatic step(input logic we, input logic [7:0] d, input logic clr);
    logic dropped;
    @(negedge clk);
    chk("level", 32'(level), 32'(cnt));
    chk("full", 32'(full), 32'(cnt == DEPTH));
    chk("empty", 32'(empty), 32'(cnt == 0));
    chk("overflow", 32'(overflow), 32'(ovf));
    wr_en        = we;
    wr_data      = d;
    clr_overflow = clr;
    dropped      = we && (cnt >= DEPTH);
    if (we && !dropped) begin
      exp_q.push_back(d);
      cnt++;
      pushed++;
    end
    if (dropped) ovf = 1'b1;
    else if (clr) ovf = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (cnt != 0 && n < budget) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes left, expected 0", cnt);
    end
    repeat (3) step(1'b0, 8'h00, 1'b0);
  endtask

  // simpleuart stand-in: while a write is pending, keep wait high for a random span.
  always begin
    @(negedge clk);
    if (uart_dat_we) begin
      if (remaining > 0) begin
        busy = 1'b1;
        remaining--;
      end else begin
        busy = 1'b0;
      end
    end else begin
      busy      = 1'b0;
      remaining = $urandom_range(wmax, wmin);
    end
  end

  // Monitor: every accepted UART write must match the model's oldest byte.
  logic        prev_send  = 1'b0;
  logic        expect_low = 1'b0;
  logic [31:0] held_di    = '0;
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_send  = 1'b0;
      expect_low = 1'b0;
    end else begin
      if (expect_low) begin
        chk("gap_low", 32'(uart_dat_we), 32'd0);
        expect_low = 1'b0;
      end
      if (uart_dat_we) begin
        if (prev_send) chk("di_stable", uart_dat_di, held_di);
        held_di = uart_dat_di;
        if (!uart_dat_wait) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %0h expected no write", uart_dat_di);
          end else begin
            chk("uart_byte", uart_dat_di, {24'b0, exp_q.pop_front()});
            cnt--;
          end
          sent++;
          expect_low = 1'b1;
        end
      end
      prev_send = uart_dat_we && uart_dat_wait;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_seen;
    int n;
    rst          = 1'b1;
    wr_en        = 1'b0;
    wr_data      = 8'h00;
    clr_overflow = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_we", 32'(uart_dat_we), 32'd0);
    chk("rst_di", uart_dat_di, 32'd0);
    rst = 1'b0;

    // Single byte latency with wait tied low.
    wmin = 0; wmax = 0;
    step(1'b1, 8'h41, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("lat_we_e0", 32'(uart_dat_we), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("lat_we_e1", 32'(uart_dat_we), 32'd1);
    chk("lat_di_e1", uart_dat_di, 32'h0000_0041);
    step(1'b0, 8'h00, 1'b0);
    chk("lat_empty_e2", 32'(empty), 32'd1);
    chk("lat_level_e2", 32'(level), 32'd0);
    drain(20);

    // Three bytes against a slow UART.
    wmin = 100; wmax = 100;
    step(1'b1, 8'h48, 1'b0);
    step(1'b1, 8'h69, 1'b0);
    step(1'b1, 8'h0A, 1'b0);
    drain(600);

    // Overflow: 17 pushes while the UART stalls.
    wmin = 0; wmax = 0;
    hold_wait = 1'b1;
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    step(1'b1, 8'h55, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    hold_wait = 1'b0;
    drain(200);

    // Push and pop on the same edge at level 5.
    hold_wait = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("l5_before", 32'(level), 32'd5);
    hold_wait = 1'b0;
    wr_en     = 1'b1;
    wr_data   = 8'hA5;
    exp_q.push_back(8'hA5);
    cnt++;
    pushed++;
    step(1'b0, 8'h00, 1'b0);
    chk("l5_after", 32'(level), 32'd5);
    wmin = 0; wmax = 3;
    drain(200);

    // Random stream, pushes gated on the model's full condition.
    wmin = 0; wmax = 20;
    n = 0;
    for (int i = 0; i < 200 && n < 20000; ) begin
      if ($urandom_range(1, 0) == 1 && cnt < DEPTH) begin
        step(1'b1, 8'($urandom), 1'b0);
        i++;
      end else begin
        step(1'b0, 8'h00, 1'b0);
      end
      n++;
    end
    drain(8000);
    chk("stream_no_ovf", 32'(overflow), 32'd0);

    // Reset in the middle of a stalled transfer.
    wmin = 0; wmax = 0;
    hold_wait = 1'b1;
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 10 && !uart_dat_we; i++) step(1'b0, 8'h00, 1'b0);
    chk("rst_mid_send_we", 32'(uart_dat_we), 32'd1);
    @(negedge clk);
    wr_en = 1'b0;
    rst   = 1'b1;
    exp_q.delete();
    cnt = 0;
    ovf = 1'b0;
    @(negedge clk);
    chk("rst2_we", 32'(uart_dat_we), 32'd0);
    chk("rst2_empty", 32'(empty), 32'd1);
    chk("rst2_level", 32'(level), 32'd0);
    chk("rst2_overflow", 32'(overflow), 32'd0);
    rst       = 1'b0;
    hold_wait = 1'b0;
    we_seen   = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (uart_dat_we) we_seen++;
    end
    chk("rst2_no_writes", 32'(we_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
